// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches over req/ack, issues over valid/ready,
// and holds fetch on JAL/JALR/BRANCH until execute resolves. Optional counters: FETCH_PERF_CNT_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        br_resolved,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] fetch_pc,
  output logic        ct_pending,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_stall
);

  typedef enum logic [1:0] {FETCH, ISSUE, RESOLVE} state_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      state, nxt;
  logic [31:0] pc_nxt;
  logic        fetch_done, is_ct, is_branch;

  // Opcode comes from the latched word so decode stalls never see a changing opcode.
  assign is_branch = (inst[6:0] == OP_BRANCH);
  assign is_ct     = is_branch || (inst[6:0] == OP_JAL) || (inst[6:0] == OP_JALR);
  assign fetch_done = imem_req && imem_ack;
  assign imem_addr  = fetch_pc;

  always_comb begin
    nxt    = state;
    pc_nxt = fetch_pc;
    case (state)
      FETCH: if (fetch_done) nxt = ISSUE;
      ISSUE: begin
        if (inst_ready) begin
          if (is_ct) begin
            nxt = RESOLVE;
          end else begin
            nxt    = FETCH;
            pc_nxt = fetch_pc + 32'd4;
          end
        end
      end
      RESOLVE: begin
        if (br_resolved) begin
          nxt    = FETCH;
          pc_nxt = (is_branch && !br_taken) ? fetch_pc + 32'd4
                                            : (br_target & 32'hFFFF_FFFC);
        end
      end
      default: nxt = FETCH;
    endcase
  end

  // Handshake outputs are registered from the next state; imem_req stays low during reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= FETCH;
      fetch_pc   <= RESET_PC;
      inst       <= 32'h0;
      inst_pc    <= 32'h0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      ct_pending <= 1'b0;
    end else begin
      state      <= nxt;
      fetch_pc   <= pc_nxt;
      imem_req   <= (nxt == FETCH);
      inst_valid <= (nxt == ISSUE);
      ct_pending <= (nxt == RESOLVE);
      if (state == FETCH && fetch_done) begin
        inst    <= imem_rdata;
        inst_pc <= fetch_pc;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_q, stall_q;
  logic        retire_ev, stall_ev;

  assign retire_ev = (state == ISSUE) && inst_ready;
  assign stall_ev  = (imem_req && !imem_ack) || (state == RESOLVE && !br_resolved);

  // Saturating counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      retired_q <= 32'h0;
      stall_q   <= 32'h0;
    end else begin
      if (retire_ev && retired_q != 32'hFFFF_FFFF) retired_q <= retired_q + 32'd1;
      if (stall_ev && stall_q != 32'hFFFF_FFFF)    stall_q   <= stall_q + 32'd1;
    end
  end

  assign perf_retired = retired_q;
  assign perf_stall   = stall_q;
`else
  assign perf_retired = 32'h0;
  assign perf_stall   = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; a second instance covers a wrapping RESET_PC.
module tb_fetch_ctrl;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_ready = 1'b0;
  logic        br_resolved = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;

  logic        imem_req, inst_valid, ct_pending;
  logic [31:0] imem_addr, inst, inst_pc, fetch_pc, perf_retired, perf_stall;
  logic        w_imem_req, w_inst_valid, w_ct_pending;
  logic [31:0] w_imem_addr, w_inst, w_inst_pc, w_fetch_pc, w_perf_retired, w_perf_stall;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] JALR = 32'h0000_8067;
  localparam logic [31:0] JAL  = 32'h0000_006F;
`ifdef FETCH_PERF_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd4;
  localparam logic [31:0] EXP_RET   = 32'd1;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
  localparam logic [31:0] EXP_RET   = 32'd0;
`endif

  fetch_ctrl dut (
    .CLK(CLK), .RESET(RESET), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .br_resolved(br_resolved), .br_taken(br_taken), .br_target(br_target),
    .fetch_pc(fetch_pc), .ct_pending(ct_pending),
    .perf_retired(perf_retired), .perf_stall(perf_stall)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .CLK(CLK), .RESET(RESET), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(w_inst_valid),
    .inst(w_inst), .inst_pc(w_inst_pc), .inst_ready(inst_ready),
    .br_resolved(br_resolved), .br_taken(br_taken), .br_target(br_target),
    .fetch_pc(w_fetch_pc), .ct_pending(w_ct_pending),
    .perf_retired(w_perf_retired), .perf_stall(w_perf_stall)
  );

  always #5 CLK = ~CLK;

  // Inputs change and outputs are checked on the falling edge.
  task automatic step;
    @(negedge CLK);
  endtask

  task automatic do_reset;
    RESET = 1'b1; imem_ack = 1'b0; inst_ready = 1'b0;
    br_resolved = 1'b0; br_taken = 1'b0;
    step; step;
    RESET = 1'b0;
    step;
  endtask

  // One fetch with same-cycle ack followed by same-cycle ready.
  task automatic issue_one(input logic [31:0] word);
    imem_ack = 1'b1; imem_rdata = word; inst_ready = 1'b1;
    step;
    imem_ack = 1'b0;
    step;
    inst_ready = 1'b0;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    step; step;
    total++; if (fetch_pc !== 32'h0) begin bad++; $display("FAIL rst_fetch_pc got=%h exp=0", fetch_pc); end
    total++; if (w_fetch_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL rst_w_fetch_pc got=%h exp=fffffffc", w_fetch_pc); end
    total++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h/%h exp=0/0", inst, inst_pc); end
    total++; if ({imem_req, inst_valid, ct_pending} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {imem_req, inst_valid, ct_pending}); end
    total++; if (perf_retired !== 32'h0 || perf_stall !== 32'h0) begin bad++; $display("FAIL rst_perf got=%h/%h exp=0/0", perf_retired, perf_stall); end
    RESET = 1'b0;
    step;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL first_req got=%b/%h exp=1/0", imem_req, imem_addr); end
  endtask

  task automatic test_sequential;
    logic [31:0] word;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      word = ADDI + (i << 20);
      total++; if (imem_req !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 32'(i * 4)) begin bad++; $display("FAIL seq_fetch%0d got=%b/%b/%h exp=1/0/%h", i, imem_req, inst_valid, imem_addr, i * 4); end
      imem_ack = 1'b1; imem_rdata = word; inst_ready = 1'b1;
      step;
      total++; if (inst_valid !== 1'b1 || imem_req !== 1'b0 || inst !== word || inst_pc !== 32'(i * 4)) begin bad++; $display("FAIL seq_issue%0d got=%b/%b/%h/%h exp=1/0/%h/%h", i, inst_valid, imem_req, inst, inst_pc, word, i * 4); end
      imem_ack = 1'b0;
      step;
    end
    inst_ready = 1'b0;
    total++; if (imem_addr !== 32'hC) begin bad++; $display("FAIL seq_end got=%h exp=c", imem_addr); end
  endtask

  task automatic test_branch(input logic taken, input logic [31:0] exp_addr);
    int cnt;
    do_reset;
    for (int i = 0; i < 4; i++) issue_one(ADDI);
    total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL br_pre got=%h exp=10", imem_addr); end
    issue_one(BEQ);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (ct_pending === 1'b1 && imem_req === 1'b0) cnt++;
      br_resolved = (k == 2); br_taken = taken; br_target = 32'h40;
      step;
    end
    br_resolved = 1'b0;
    total++; if (cnt !== 3 || ct_pending !== 1'b0) begin bad++; $display("FAIL br_pending%0d got=%0d/%b exp=3/0", taken, cnt, ct_pending); end
    total++; if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin bad++; $display("FAIL br_target%0d got=%b/%h exp=1/%h", taken, imem_req, imem_addr, exp_addr); end
  endtask

  task automatic test_jump;
    do_reset;
    issue_one(JALR);
    total++; if (ct_pending !== 1'b1) begin bad++; $display("FAIL jalr_pending got=%b exp=1", ct_pending); end
    br_resolved = 1'b1; br_taken = 1'b0; br_target = 32'h103;
    step;
    br_resolved = 1'b0;
    total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL jalr_target got=%h exp=100", imem_addr); end
    issue_one(JAL);
    br_resolved = 1'b1; br_taken = 1'b0; br_target = 32'h20A;
    step;
    br_resolved = 1'b0;
    total++; if (imem_addr !== 32'h208) begin bad++; $display("FAIL jal_target got=%h exp=208", imem_addr); end
  endtask

  task automatic test_stall;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL stall_req%0d got=%b/%h exp=1/0", i, imem_req, imem_addr); end
      step;
    end
    imem_ack = 1'b1; imem_rdata = ADDI;
    step;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      total++; if (inst_valid !== 1'b1 || inst !== ADDI || inst_pc !== 32'h0 || imem_addr !== 32'h0) begin bad++; $display("FAIL stall_hold%0d got=%b/%h/%h/%h exp=1/%h/0/0", i, inst_valid, inst, inst_pc, imem_addr, ADDI); end
      step;
    end
    imem_ack = 1'b0; inst_ready = 1'b1;
    step;
    inst_ready = 1'b0;
    total++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin bad++; $display("FAIL stall_next got=%b/%h exp=1/4", imem_req, imem_addr); end
    total++; if (perf_stall !== EXP_STALL || perf_retired !== EXP_RET) begin bad++; $display("FAIL stall_perf got=%0d/%0d exp=%0d/%0d", perf_stall, perf_retired, EXP_STALL, EXP_RET); end
  endtask

  task automatic test_wrap;
    do_reset;
    total++; if (w_imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_start got=%h exp=fffffffc", w_imem_addr); end
    issue_one(ADDI);
    total++; if (w_imem_addr !== 32'h0 || imem_addr !== 32'h4) begin bad++; $display("FAIL wrap_next got=%h/%h exp=0/4", w_imem_addr, imem_addr); end
    br_resolved = 1'b1; br_taken = 1'b1; br_target = 32'h80;
    step; step;
    br_resolved = 1'b0;
    total++; if (imem_addr !== 32'h4 || w_imem_addr !== 32'h0 || imem_req !== 1'b1 || ct_pending !== 1'b0) begin bad++; $display("FAIL spurious_res got=%h/%h/%b/%b exp=4/0/1/0", imem_addr, w_imem_addr, imem_req, ct_pending); end
  endtask

  task automatic test_reset_resolve;
    do_reset;
    issue_one(ADDI);
    issue_one(BEQ);
    total++; if (ct_pending !== 1'b1 || fetch_pc !== 32'h4) begin bad++; $display("FAIL rr_pending got=%b/%h exp=1/4", ct_pending, fetch_pc); end
    RESET = 1'b1; br_resolved = 1'b1; br_taken = 1'b1; br_target = 32'h40;
    step;
    total++; if (fetch_pc !== 32'h0 || {imem_req, inst_valid, ct_pending} !== 3'b000 || inst !== 32'h0) begin bad++; $display("FAIL rr_reset got=%h/%b/%h exp=0/000/0", fetch_pc, {imem_req, inst_valid, ct_pending}, inst); end
    RESET = 1'b0; br_resolved = 1'b0;
    step;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rr_refetch got=%b/%h exp=1/0", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_branch(1'b1, 32'h40);
    test_branch(1'b0, 32'h14);
    test_jump;
    test_stall;
    test_wrap;
    test_reset_resolve;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the multicycle core: owns the program counter register and sequences instruction memory, decode handoff and control-transfer resolution. It fetches one instruction at a time over a req/ack handshake, presents it to decode over a valid/ready handshake, and holds fetch for every JAL, JALR or BRANCH until execute reports the outcome. Sits between instruction memory, the decode stage and the execute-stage branch unit.

## Interface

- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `CLK` in 1: clock, rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; equals `fetch_pc`.
- `imem_ack` in 1: memory returns `imem_rdata` this cycle.
- `imem_rdata` in 32: fetched instruction word.
- `inst_valid` out 1: `inst`/`inst_pc` valid to decode.
- `inst` out 32: latched instruction.
- `inst_pc` out 32: PC of `inst`.
- `inst_ready` in 1: decode accepts `inst`.
- `br_resolved` in 1: execute outcome valid this cycle.
- `br_taken` in 1: branch condition true; qualified by `br_resolved`.
- `br_target` in 32: absolute target address; qualified by `br_resolved`.
- `fetch_pc` out 32: current PC.
- `ct_pending` out 1: high in RESOLVE.
- `perf_retired` out 32: issued-instruction count.
- `perf_stall` out 32: stall-cycle count.

## Operation

- Reset values: `fetch_pc`=RESET_PC, `inst`=0, `inst_pc`=0, all 1-bit outputs 0, `perf_*`=0, state FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`fetch_pc`, both held stable until ack. On `imem_ack`, latch `imem_rdata`→`inst` and `fetch_pc`→`inst_pc`, then go to ISSUE.
- ISSUE: `inst_valid`=1. `inst` and `inst_pc` hold until `inst_ready`. On `inst_ready`:
  - if `inst[6:0]` ∈ {7'b1101111 JAL, 7'b1100111 JALR, 7'b1100011 BRANCH}, go to RESOLVE;
  - otherwise `fetch_pc`←`fetch_pc`+4 and go to FETCH.
- RESOLVE: `ct_pending`=1, no fetch. On `br_resolved`:
  - if opcode is JAL/JALR, or BRANCH with `br_taken`=1: `fetch_pc`←{`br_target`[31:2],2'b00};
  - BRANCH with `br_taken`=0: `fetch_pc`←`fetch_pc`+4.
  - Go to FETCH.
- Opcode is decoded from the latched `inst`, never from `imem_rdata`.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
- Ignored inputs: `imem_ack` outside FETCH; `inst_ready` outside ISSUE; `br_resolved` outside RESOLVE. `br_taken` is ignored for JAL/JALR.
- RESET at any state, including mid-handshake, abandons the operation. All outputs take reset values at that edge, and a pending ack or resolve is dropped.

## Timing

- All state and outputs are registered on the rising `CLK` edge; outputs are decoded from state and registers only.
- `imem_ack` is allowed in the first cycle of `imem_req`. Minimum FETCH occupancy is 1 cycle.
- `inst_ready` is allowed in the first cycle of `inst_valid`.
- Best-case throughput for non-control instructions: 2 cycles per instruction (FETCH, ISSUE).
- Control transfer: at least 3 cycles (FETCH, ISSUE, RESOLVE ≥1).
- The first `imem_req` after reset deassertion occurs in the cycle following the edge where RESET is sampled low.

## Configuration

- `FETCH_PERF_CNT_EN` defined:
  - `perf_retired` increments on each ISSUE cycle with `inst_ready`=1.
  - `perf_stall` increments on each FETCH cycle with `imem_ack`=0 and each RESOLVE cycle with `br_resolved`=0.
  - Both saturate at 32'hFFFF_FFFF and clear on RESET.
- Undefined: the counter logic is absent, and both ports are tied to 32'h0.

## Test plan

- Reset, then `imem_ack` in the same cycle as req, `inst_ready`=1, three ADDI words (opcode 7'b0010011) → `imem_addr` sequence 0x0, 0x4, 0x8; `inst_valid` every second cycle.
- BRANCH at 0x10, `br_resolved` after 2 cycles with `br_taken`=1, `br_target`=0x40 → `ct_pending` high for 3 cycles, next `imem_addr`=0x40. Repeat with `br_taken`=0 → next `imem_addr`=0x14.
- JALR with `br_taken`=0, `br_target`=0x103 → next `imem_addr`=0x100.
- `imem_ack` delayed 4 cycles and `inst_ready` delayed 3 cycles → `imem_addr`, `inst` and `inst_pc` are stable throughout. With `FETCH_PERF_CNT_EN`, `perf_stall`=4 and `perf_retired`=1.
- RESET_PC=32'hFFFF_FFFC, non-control instruction → next `imem_addr`=0x0. Spurious `br_resolved` during FETCH → no PC change.
- RESET asserted during RESOLVE with simultaneous `br_resolved` → next cycle `fetch_pc`=RESET_PC, `ct_pending`=0, `inst_valid`=0.
